// File: rtl/regfile_pkg.sv
// Shared types and constants for the tagged register file.
// The per-register entry struct is sized by the core's XLEN/TAG_W below.
package regfile_pkg;

    localparam int REG_XLEN  = 32;
    localparam int REG_TAG_W = 4;

    localparam logic [REG_XLEN-1:0]  ZERO_WORD = '0;
    localparam logic [REG_TAG_W-1:0] ZERO_TAG  = '0;

    typedef struct packed {
        logic [REG_XLEN-1:0]  data;
        logic                 busy;
        logic [REG_TAG_W-1:0] tag;
    } reg_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_tagged_if.sv
// Issue/commit/flush/read bundle between the issue and commit stages and the register file.
// No handshake: each enable is a one-cycle pulse, accepted whenever rdy_in is high.
interface regfile_tagged_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = REG_XLEN,
    parameter int NREG  = 32,
    parameter int TAG_W = REG_TAG_W,
    parameter int NRD   = 2
);
    localparam int AW = clog2(NREG);

    logic                  rdy_in;
    logic                  issue_en;
    logic [AW-1:0]         issue_rd;
    logic [TAG_W-1:0]      issue_tag;
    logic                  commit_en;
    logic [AW-1:0]         commit_rd;
    logic [TAG_W-1:0]      commit_tag;
    logic [XLEN-1:0]       commit_data;
    logic                  flush;
    logic [NRD*AW-1:0]     raddr;
    logic [NRD*XLEN-1:0]   rdata;
    logic [NRD-1:0]        rbusy;
    logic [NRD*TAG_W-1:0]  rtag;
    logic [AW:0]           busy_cnt;

    modport master (
        output rdy_in, issue_en, issue_rd, issue_tag,
        output commit_en, commit_rd, commit_tag, commit_data, flush, raddr,
        input  rdata, rbusy, rtag, busy_cnt
    );

    modport slave (
        input  rdy_in, issue_en, issue_rd, issue_tag,
        input  commit_en, commit_rd, commit_tag, commit_data, flush, raddr,
        output rdata, rbusy, rtag, busy_cnt
    );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: entry mux, x0 and reset forcing, and the optional
// commit-to-read forward enabled by REGFILE_BYPASS_EN.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic                  rst,
    input  logic [AW-1:0]         raddr,
    input  reg_entry_t            regs [NREG],
    input  logic                  commit_fire,
    input  logic [AW-1:0]         commit_rd,
    input  logic [REG_TAG_W-1:0]  commit_tag,
    input  logic [REG_XLEN-1:0]   commit_data,
    output logic [REG_XLEN-1:0]   rdata,
    output logic                  rbusy,
    output logic [REG_TAG_W-1:0]  rtag
);

    reg_entry_t sel;

    always_comb begin
        rdata = ZERO_WORD;
        rbusy = 1'b0;
        rtag  = ZERO_TAG;
        sel   = regs[raddr];
        if (!rst && raddr != '0) begin
            rdata = sel.data;
            rbusy = sel.busy;
            rtag  = sel.tag;
`ifdef REGFILE_BYPASS_EN
            // Retiring value wins; busy survives only if a younger producer owns the register.
            if (commit_fire && commit_rd == raddr) begin
                rdata = commit_data;
                rbusy = sel.busy && (sel.tag != commit_tag);
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{commit_fire, commit_rd, commit_tag, commit_data};
`endif

endmodule

// File: rtl/regfile_tagged.sv
// Architectural register file with per-register busy bit and producer tag for renaming.
// Define REGFILE_BYPASS_EN to forward a same-cycle commit onto the read ports.
module regfile_tagged
    import regfile_pkg::*;
#(
    parameter int XLEN  = REG_XLEN,
    parameter int NREG  = 32,
    parameter int TAG_W = REG_TAG_W,
    parameter int NRD   = 2
) (
    input logic             clk_in,
    input logic             rst,
    regfile_tagged_if.slave bus
);

    localparam int AW = clog2(NREG);

    reg_entry_t       regs_q [NREG];
    reg_entry_t       regs_n [NREG];
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_n;

    // Commit checks the pre-issue tag; issue then overrides busy/tag, flush drops both.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_n[i] = regs_q[i];
            if (i != 0) begin
                if (bus.commit_en && bus.commit_rd == AW'(i)) begin
                    regs_n[i].data = bus.commit_data;
                    if (regs_q[i].busy && regs_q[i].tag == bus.commit_tag)
                        regs_n[i].busy = 1'b0;
                end
                if (bus.flush) begin
                    regs_n[i].busy = 1'b0;
                end else if (bus.issue_en && bus.issue_rd == AW'(i)) begin
                    regs_n[i].busy = 1'b1;
                    regs_n[i].tag  = bus.issue_tag;
                end
            end else begin
                regs_n[i] = '0;
            end
        end
    end

    always_comb begin
        cnt_n = '0;
        for (int i = 0; i < NREG; i++)
            cnt_n = cnt_n + (AW+1)'(regs_n[i].busy);
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            cnt_q <= '0;
        end else if (bus.rdy_in) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= regs_n[i];
            cnt_q <= cnt_n;
        end
    end

    assign bus.busy_cnt = cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        regfile_read_port #(
            .NREG (NREG),
            .AW   (AW)
        ) u_port (
            .rst         (rst),
            .raddr       (bus.raddr[p*AW +: AW]),
            .regs        (regs_q),
            .commit_fire (bus.commit_en && bus.rdy_in),
            .commit_rd   (bus.commit_rd),
            .commit_tag  (bus.commit_tag),
            .commit_data (bus.commit_data),
            .rdata       (bus.rdata[p*XLEN +: XLEN]),
            .rbusy       (bus.rbusy[p]),
            .rtag        (bus.rtag[p*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed bench for regfile_tagged: rename busy/tag tracking, flush, x0, stall and bypass timing.
module tb_regfile_tagged;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int TAG_W = 4;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic clk_in = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    regfile_tagged_if #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) bus ();

    regfile_tagged #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    task automatic idle();
        bus.rdy_in      = 1'b1;
        bus.issue_en    = 1'b0;
        bus.issue_rd    = '0;
        bus.issue_tag   = '0;
        bus.commit_en   = 1'b0;
        bus.commit_rd   = '0;
        bus.commit_tag  = '0;
        bus.commit_data = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        idle();
    endtask

    task automatic issue(input int rd, input int tag);
        bus.issue_en  = 1'b1;
        bus.issue_rd  = AW'(rd);
        bus.issue_tag = TAG_W'(tag);
    endtask

    task automatic commit(input int rd, input int tag, input logic [XLEN-1:0] data);
        bus.commit_en   = 1'b1;
        bus.commit_rd   = AW'(rd);
        bus.commit_tag  = TAG_W'(tag);
        bus.commit_data = data;
    endtask

    task automatic read(input int a0, input int a1);
        bus.raddr = {AW'(a1), AW'(a0)};
        #1;
    endtask

    function automatic logic [XLEN-1:0] rd0();
        return bus.rdata[0 +: XLEN];
    endfunction
    function automatic logic [XLEN-1:0] rd1();
        return bus.rdata[XLEN +: XLEN];
    endfunction
    function automatic logic [TAG_W-1:0] tg0();
        return bus.rtag[0 +: TAG_W];
    endfunction

    initial begin
        idle();
        bus.raddr = '0;
        rst = 1'b1;
        step();
        step();
        read(5, 7);
        check("reset_rdata0", rd0(), 0);
        check("reset_rbusy", bus.rbusy, 0);
        check("reset_cnt", bus.busy_cnt, 0);
        rst = 1'b0;

        // Issue then commit with matching tag
        issue(5, 3);
        step();
        read(5, 0);
        check("x5_busy", bus.rbusy[0], 1);
        check("x5_tag", tg0(), 3);
        check("cnt_after_issue", bus.busy_cnt, 1);
        commit(5, 3, 32'hDEADBEEF);
        step();
        read(5, 0);
        check("x5_data", rd0(), 32'hDEADBEEF);
        check("x5_cleared", bus.rbusy[0], 0);
        check("cnt_after_commit", bus.busy_cnt, 0);

        // Older commit must not clear a younger producer
        issue(7, 1);
        step();
        issue(7, 2);
        step();
        commit(7, 1, 32'h11);
        step();
        read(7, 5);
        check("x7_data", rd0(), 32'h11);
        check("x7_busy", bus.rbusy[0], 1);
        check("x7_tag", tg0(), 2);
        check("port1_x5", rd1(), 32'hDEADBEEF);
        check("port1_x5_busy", bus.rbusy[1], 0);
        check("cnt_x7", bus.busy_cnt, 1);

        // Same-cycle issue+commit: issue wins busy/tag
        issue(9, 6);
        step();
        check("cnt_x9_pre", bus.busy_cnt, 2);
        issue(9, 4);
        commit(9, 6, 32'h22);
        step();
        read(9, 0);
        check("x9_data", rd0(), 32'h22);
        check("x9_busy", bus.rbusy[0], 1);
        check("x9_tag", tg0(), 4);
        check("cnt_x9_post", bus.busy_cnt, 2);

        // rdy_in low: nothing changes
        bus.rdy_in = 1'b0;
        commit(7, 2, 32'h99);
        issue(12, 1);
        step();
        read(7, 12);
        check("stall_x7_data", rd0(), 32'h11);
        check("stall_x7_busy", bus.rbusy[0], 1);
        check("stall_x12_busy", bus.rbusy[1], 0);
        check("stall_cnt", bus.busy_cnt, 2);

        // Flush with a same-cycle issue
        issue(1, 8);
        step();
        issue(2, 9);
        step();
        issue(3, 10);
        step();
        check("cnt_pre_flush", bus.busy_cnt, 5);
        bus.flush = 1'b1;
        issue(4, 11);
        step();
        read(1, 2);
        check("flush_x1", bus.rbusy[0], 0);
        check("flush_x2", bus.rbusy[1], 0);
        read(3, 4);
        check("flush_x3", bus.rbusy[0], 0);
        check("flush_x4", bus.rbusy[1], 0);
        check("flush_cnt", bus.busy_cnt, 0);
        read(5, 7);
        check("flush_x5_data", rd0(), 32'hDEADBEEF);
        check("flush_x7_data", rd1(), 32'h11);

        // Register 0 ignores writes
        issue(0, 7);
        commit(0, 7, 32'hFFFF);
        step();
        read(0, 0);
        check("x0_data", rd0(), 0);
        check("x0_busy", bus.rbusy[0], 0);
        check("x0_tag", tg0(), 0);
        check("x0_cnt", bus.busy_cnt, 0);

        // Commit visibility timing on the read port
        read(10, 0);
        commit(10, 5, 32'h33);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x10_same_cycle", rd0(), 32'h33);
`else
        check("x10_same_cycle", rd0(), 0);
`endif
        check("x10_same_busy", bus.rbusy[0], 0);
        step();
        read(10, 0);
        check("x10_next_cycle", rd0(), 32'h33);

        // Reset forces reads combinationally, then clears storage
        rst = 1'b1;
        read(7, 10);
        check("rst_force_port0", rd0(), 0);
        check("rst_force_port1", rd1(), 0);
        step();
        rst = 1'b0;
        read(7, 10);
        check("post_rst_x7", rd0(), 0);
        check("post_rst_x10", rd1(), 0);
        check("post_rst_cnt", bus.busy_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_tagged.md
# regfile_tagged

Parametrised architectural register file for the out-of-order RISC-V core, extending the plain register file with a per-register busy bit and producer tag (ROB index) so that the issue stage can rename sources. It sits between decode/issue (which reads sources and claims destinations) and the commit stage (which retires results in order). It has NRD read ports, an optional commit-to-read bypass, a global flush for mispredict recovery, and a registered busy-register count.

## Interface
- XLEN, 32: data width.
- NREG, 32: number of registers; power of two, ≥ 2; register 0 is hard-wired zero.
- TAG_W, 4: producer tag width.
- NRD, 2: number of read ports.
- Derived: AW = log2(NREG).

- clk_in  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy_in  in  1  global ready; when low, all state holds.
- issue_en  in  1  claim destination register.
- issue_rd  in  AW  destination register index.
- issue_tag  in  TAG_W  producer tag of the issuing instruction.
- commit_en  in  1  retire a result.
- commit_rd  in  AW  retiring destination.
- commit_tag  in  TAG_W  tag of the retiring instruction.
- commit_data  in  XLEN  retired value.
- flush  in  1  clear all busy bits.
- raddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data.
- rbusy  out  NRD  register has an outstanding producer.
- rtag  out  NRD*TAG_W  producer tag; valid only when rbusy.
- busy_cnt  out  AW+1  number of busy registers, registered.

## Operation
- Per-register state: data[XLEN], busy, tag[TAG_W]. Register 0 is never written, never busy, and always reads 0/0/0.
- Commit (commit_en, commit_rd≠0): data ← commit_data unconditionally. busy is cleared only if tag == commit_tag; on a mismatch busy and tag are kept, because a younger producer owns the register.
- Issue (issue_en, issue_rd≠0): busy ← 1, tag ← issue_tag.
- Issue and commit to the same register in the same cycle: data is written, busy stays 1, and tag becomes issue_tag (issue wins).
- Flush: every busy bit is cleared; data is still written by a same-cycle commit; a same-cycle issue is dropped.
- busy_cnt tracks the number of set busy bits. It is recomputed from the next-state busy vector and equals the popcount at every cycle boundary. Flush sets it to 0.
- Read port i, combinational:
  - raddr 0 → rdata, rbusy and rtag are all zero.
  - Otherwise the port returns the stored data, busy and tag, subject to the bypass rule under Configuration.
  - A same-cycle issue is never visible on a read port. A reader sees pre-issue state, so an instruction with rs == rd gets the old producer.
- rst while high: all data, busy, tag and busy_cnt are cleared at the clock edge. All read outputs are forced to 0 combinationally.
- rdy_in low: no state update; reads remain live.

## Timing
- Reads: 0-cycle combinational.
- Writes, busy and tag updates: visible on reads in the cycle after the edge.
- busy_cnt: reflects updates one cycle after the edge.
- Reset values: rdata = 0, rbusy = 0, rtag = 0, busy_cnt = 0.
- There is no handshake; every enable is a single-cycle pulse that is accepted unconditionally when rdy_in is high.

## Configuration
- REGFILE_BYPASS_EN defined: a read port whose raddr equals commit_rd (≠0) while commit_en is high returns:
  - rdata = commit_data;
  - rbusy = stored busy AND (stored tag ≠ commit_tag).
  - This gives 0-cycle forwarding of the retiring value.
- Undefined: reads return stored state only. A committed value is visible one cycle later, and the issue logic must stall one cycle.

## Structure
- Package regfile_pkg holds:
  - the ZeroWord and zero-tag constants;
  - a clog2 helper for AW;
  - the per-register entry struct {data, busy, tag}.
- Sub-module regfile_read_port holds one port's mux, zero-register check, reset force and bypass. It is instantiated NRD times via generate.

## Test plan
- Reset, then issue x5 with tag 3: the next cycle a read of x5 gives rbusy = 1, rtag = 3, busy_cnt = 1. Commit x5 with tag 3 and data 0xDEADBEEF: the next cycle gives rdata = 0xDEADBEEF, rbusy = 0, busy_cnt = 0.
- Issue x7 with tag 1, then issue x7 with tag 2, then commit x7 with tag 1 and data 0x11: x7 reads 0x11 with rbusy = 1 and rtag = 2.
- Issue x9 with tag 4 and commit x9 with tag 6 and data 0x22 in the same cycle, x9 previously busy with tag 6: x9 reads 0x22 with rbusy = 1, rtag = 4, busy_cnt unchanged.
- Issue x1, x2, x3, then flush together with an issue of x4: rbusy = 0 on all four registers and busy_cnt = 0. Stored data is unchanged.
- Writes to x0 (issue and commit): x0 always reads 0/0/0 and busy_cnt never counts it.
- With REGFILE_BYPASS_EN, commit x10 with data 0x33 and tag 5 while raddr0 = x10: rdata0 = 0x33 in the same cycle. Without the macro, rdata0 shows the old value and reads 0x33 one cycle later.
